// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// btn_debouncer
//   Debounces one raw push-button/switch input. The raw level is first
//   brought into the clk domain by a two-flop synchronizer. A four-state
//   FSM then requires the synchronized level to stay stable for 2^N
//   cycles before it changes the debounced level. A single-cycle tick is
//   produced only on a qualified 0->1 transition. Each physical press
//   therefore gives exactly one tick, which makes the tick safe to use as
//   a FIFO read or write strobe.
//
// Parameters
//   N         stability counter width; input must be stable 2^N clk cycles
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   sw        in   raw, asynchronous, bouncing button/switch level
//   db_level  out  debounced level (registered)
//   db_tick   out  one-cycle pulse on each debounced 0->1 transition (registered)
// ---------------------------------------------------------------------------
module btn_debouncer #(
    parameter int N = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [N-1:0] Q_FULL = {N{1'b1}};
    localparam logic [N-1:0] Q_ZERO = {N{1'b0}};
    localparam logic [N-1:0] Q_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic   sync0_r;
    logic   sync1_r;
    logic   sw_s;
    state_t state_r;
    state_t state_nxt_s;
    logic [N-1:0] q_r;
    logic [N-1:0] q_nxt_s;
    logic   level_nxt_s;
    logic   tick_nxt_s;
    logic   db_level_r;
    logic   db_tick_r;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
        end else begin
            sync0_r <= sw;
            sync1_r <= sync0_r;
        end
    end

    assign sw_s = sync1_r;

    // State and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ZERO;
            q_r     <= Q_ZERO;
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
        end
    end

    // Next-state and counter logic. A level change during a WAIT state
    // returns to the settled state, so the next qualification always
    // reloads the counter and starts again from the full interval.
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        case (state_r)
            ZERO: begin
                if (sw_s) begin
                    state_nxt_s = WAIT1;
                    q_nxt_s     = Q_FULL;
                end else begin
                    state_nxt_s = ZERO;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_nxt_s = ZERO;
                end else if (q_r == Q_ZERO) begin
                    state_nxt_s = ONE;
                end else begin
                    q_nxt_s = q_r - Q_ONE;
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_nxt_s = WAIT0;
                    q_nxt_s     = Q_FULL;
                end else begin
                    state_nxt_s = ONE;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_nxt_s = ONE;
                end else if (q_r == Q_ZERO) begin
                    state_nxt_s = ZERO;
                end else begin
                    q_nxt_s = q_r - Q_ONE;
                end
            end
            default: begin
                state_nxt_s = ZERO;
                q_nxt_s     = Q_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line
    // up with the state they describe. Only a WAIT1->ONE move is a press;
    // a bounce ending in WAIT0->ONE never ticks.
    always_comb begin
        level_nxt_s = 1'b0;
        tick_nxt_s  = 1'b0;
        if ((state_nxt_s == ONE) || (state_nxt_s == WAIT0)) begin
            level_nxt_s = 1'b1;
        end else begin
            level_nxt_s = 1'b0;
        end
        if ((state_r == WAIT1) && (state_nxt_s == ONE)) begin
            tick_nxt_s = 1'b1;
        end else begin
            tick_nxt_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level_r <= 1'b0;
            db_tick_r  <= 1'b0;
        end else begin
            db_level_r <= level_nxt_s;
            db_tick_r  <= tick_nxt_s;
        end
    end

    assign db_level = db_level_r;
    assign db_tick  = db_tick_r;

endmodule

// File: tb/tb_btn_debouncer.sv
// ---------------------------------------------------------------------------
// tb_btn_debouncer
//   Directed bench for btn_debouncer with N=3 (qualification interval 8).
//   Inputs change 1 time unit after a rising edge; the first rising edge
//   after a change is e0. Outputs are sampled 1 time unit after each edge.
//   With this timing, a stable level reaches db_level after e10.
// ---------------------------------------------------------------------------
module tb_btn_debouncer;

    logic clk;
    logic reset;
    logic sw;
    logic db_level;
    logic db_tick;

    int total_cnt;
    int bad_cnt;
    int tick_cnt;
    int level_max;
    int level_min;

    btn_debouncer #(.N(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick counter, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (db_tick === 1'b1) tick_cnt = tick_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while tracking the min/max of db_level.
    task automatic step_track(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (db_level === 1'b1) level_max = 1;
            if (db_level !== 1'b1) level_min = 0;
        end
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        tick_cnt  = 0;
        reset     = 1'b1;
        sw        = 1'b0;

        // Reset state.
        step();
        step();
        check_val("rst_level", {31'd0, db_level}, 32'd0);
        check_val("rst_tick",  {31'd0, db_tick},  32'd0);

        // Test 1: press held from e0.
        reset = 1'b0;
        sw    = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) step();          // after e9
        check_val("t1_level_e9", {31'd0, db_level}, 32'd0);
        check_val("t1_tick_e9",  {31'd0, db_tick},  32'd0);
        step();                                         // after e10
        check_val("t1_level_e10", {31'd0, db_level}, 32'd1);
        check_val("t1_tick_e10",  {31'd0, db_tick},  32'd1);
        step();                                         // after e11
        check_val("t1_level_e11", {31'd0, db_level}, 32'd1);
        check_val("t1_tick_e11",  {31'd0, db_tick},  32'd0);
        level_min = 1;
        step_track(20);
        check_val("t1_level_hold", level_min, 32'd1);
        check_val("t1_tick_total", tick_cnt, 32'd1);

        // Test 3: short low glitch while settled high.
        tick_cnt  = 0;
        level_min = 1;
        sw = 1'b0;
        step_track(3);
        sw = 1'b1;
        step_track(20);
        check_val("t3_level_min", level_min, 32'd1);
        check_val("t3_tick_cnt",  tick_cnt,  32'd0);

        // Test 4: release held from e0.
        tick_cnt = 0;
        sw = 1'b0;
        for (int i = 0; i < 10; i++) step();           // after e9
        check_val("t4_level_e9", {31'd0, db_level}, 32'd1);
        step();                                         // after e10
        check_val("t4_level_e10", {31'd0, db_level}, 32'd0);
        step_track(10);
        check_val("t4_tick_cnt", tick_cnt, 32'd0);

        // Test 2: 5-cycle high pulse is rejected.
        tick_cnt  = 0;
        level_max = 0;
        sw = 1'b1;
        step_track(5);
        sw = 1'b0;
        step_track(20);
        check_val("t2_level_max", level_max, 32'd0);
        check_val("t2_tick_cnt",  tick_cnt,  32'd0);

        // Test 5: bounce then steady high.
        tick_cnt = 0;
        for (int b = 0; b < 6; b++) begin
            sw = 1'b1;
            step();
            step();
            sw = 1'b0;
            step();
            step();
        end
        check_val("t5_tick_bounce", tick_cnt, 32'd0);
        sw = 1'b1;
        for (int i = 0; i < 10; i++) step();           // after e9
        check_val("t5_level_e9", {31'd0, db_level}, 32'd0);
        step();                                         // after e10
        check_val("t5_level_e10", {31'd0, db_level}, 32'd1);
        check_val("t5_tick_e10",  {31'd0, db_tick},  32'd1);
        step_track(10);
        check_val("t5_tick_total", tick_cnt, 32'd1);

        // Asynchronous clear of a settled-high output, without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_level", {31'd0, db_level}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sw = 1'b0;
        step_track(15);
        check_val("arst_level_low", {31'd0, db_level}, 32'd0);

        // Test 6: reset while in WAIT1 with q=4, released next cycle.
        sw = 1'b1;
        for (int i = 0; i < 6; i++) step();            // after e5: WAIT1, q=4
        tick_cnt = 0;
        reset = 1'b1;
        #1;
        check_val("t6_rst_level", {31'd0, db_level}, 32'd0);
        check_val("t6_rst_tick",  {31'd0, db_tick},  32'd0);
        step();
        check_val("t6_rst_level2", {31'd0, db_level}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();           // after e9 from release
        check_val("t6_level_e9", {31'd0, db_level}, 32'd0);
        check_val("t6_tick_e9",  tick_cnt,          32'd0);
        step();                                         // after e10
        check_val("t6_level_e10", {31'd0, db_level}, 32'd1);
        check_val("t6_tick_e10",  {31'd0, db_tick},  32'd1);
        step_track(5);
        check_val("t6_tick_total", tick_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
